// File: rtl/pkg_display.sv
// Shared display types and sizes for the 3-digit BCD scan path.
package pkg_display;

  localparam int N_DIG = 3;
  localparam int BCD_W = 4;
  localparam int CDU_W = N_DIG * BCD_W;

  // One-hot digit select; the encoding is the mux select itself.
  typedef enum logic [N_DIG-1:0] {
    DIG_U = 3'b001,
    DIG_D = 3'b010,
    DIG_C = 3'b100
  } dig_sel_t;

endpackage

// File: rtl/module_prescaler.sv
// Free-running divider: pulses tick for one cycle every TICK_DIV clocks.
module module_prescaler #(
  parameter int TICK_DIV = 27_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV) + 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/module_scan_ctrl.sv
// Scans U/D/C digits, snapshots the BCD word at frame boundaries via req/ack,
// and drives active-low anodes with optional leading-zero blanking.
module module_scan_ctrl
  import pkg_display::*;
#(
  parameter int TICK_DIV = 27_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CDU_W-1:0] cdu_in,
  input  logic             upd_req,
  input  logic             blank_lz,
  output logic             upd_ack,
  output logic [CDU_W-1:0] cdu_q,
  output logic [N_DIG-1:0] a,
  output logic [N_DIG-1:0] an_n,
  output logic             frame_tick
);

  dig_sel_t state;
  dig_sel_t next_state;
  logic     tick;
  logic     boundary;
  logic     blank_c;
  logic     blank_d;

  module_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = DIG_U;
    case (state)
      DIG_U:   next_state = tick ? DIG_D : DIG_U;
      DIG_D:   next_state = tick ? DIG_C : DIG_D;
      DIG_C:   next_state = tick ? DIG_U : DIG_C;
      default: next_state = DIG_U;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= DIG_U;
    end else begin
      state <= next_state;
    end
  end

  assign boundary = tick && (state == DIG_C);

  // Snapshot only moves on the C->U edge, so a frame never mixes old and new digits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cdu_q      <= '0;
      upd_ack    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= boundary;
      upd_ack    <= boundary && upd_req;
      if (boundary && upd_req) begin
        cdu_q <= cdu_in;
      end
    end
  end

  assign a = state;

  // Blanking looks at the snapshot only; non-BCD nibbles count as non-zero.
  assign blank_c = blank_lz && (cdu_q[11:8] == 4'd0);
  assign blank_d = blank_c && (cdu_q[7:4] == 4'd0);
  assign an_n    = ~(a & ~{blank_c, blank_d, 1'b0});

endmodule
